instr_encoder: RTL and testbench
================================

# instr_encoder

Instruction encoder and program loader for the 16-bit processor. Accepts one decoded instruction per handshake (opcode plus register and immediate fields), packs it into the 16-bit word format the control unit decodes, buffers it in a small FIFO, and writes it sequentially into instruction memory through a write/acknowledge port. It sits between the host/debug loader and the instruction memory write port. It is the writer-side counterpart of the opcode decoder.

## Interface

Parameters:
- ADDR_W, 8, instruction memory address width
- FIFO_DEPTH, 4, encoded words buffered, including the word currently presented on the memory port; power of two, ≥2
- BASE_ADDR, 0, load start address after reset or restart

Ports:
- clk  in  1  clock, rising edge; the only clock
- rst  in  1  reset, synchronous and active-high
- in_valid  in  1  instruction fields valid
- in_ready  out  1  encoder can accept (FIFO not full)
- in_op  in  4  opcode
- in_rd  in  4  destination register
- in_rs  in  4  source or base register
- in_rt  in  4  second source or store-data register
- in_imm  in  12  immediate, offset or jump target, unsigned
- restart  in  1  rewind load address to BASE_ADDR
- imem_we  out  1  memory write request
- imem_addr  out  ADDR_W  write address
- imem_wdata  out  16  encoded instruction word
- imem_ack  in  1  memory accepted the write this cycle
- busy  out  1  FIFO non-empty or write pending
- word_count  out  ADDR_W+1  words acknowledged since reset/restart, wraps modulo 2^(ADDR_W+1)
- trunc_err  out  1  sticky: an immediate had nonzero bits outside its field
- wrapped  out  1  sticky: load address wrapped past 2^ADDR_W-1

## Operation

Word format (bit 15 first):
- ADD/SUB/MUL/DIV/AND/OR/XOR (0000–0110): {op, rd, rs, rt}
- NOT 0111 and MOVE 1010: {op, rd, rs, 4'h0}; in_rt ignored
- LOAD 1000: {op, rd, rs, imm[3:0]}
- STORE 1001: {op, rt, rs, imm[3:0]}
- IMMEDIATE 1011: {op, rd, imm[7:0]}
- JUMP 1100: {op, imm[11:0]}
- BEQ 1101 / BNE 1110: {op, rs, rt, imm[3:0]}
- NOP 1111: 16'hF000; all fields ignored

Encoding and checks:
- Encoding is applied on the accepting edge (in_valid && in_ready); the encoded word is written to the FIFO tail.
- trunc_err is set if any in_imm bit above the field used by the opcode is 1. Unused fields of the opcode are never checked. The word is still encoded, truncated.

Drain FSM:
- IDLE: imem_we=0. Go to WRITE when the FIFO is non-empty.
- WRITE: imem_we=1; imem_wdata = FIFO head; imem_addr = current address. Hold all three stable until imem_ack.
  - On ack: pop the head; increment the address modulo 2^ADDR_W; increment word_count.
  - After ack, stay in WRITE if further words are present, otherwise return to IDLE.
- Address wrap (address == 2^ADDR_W-1 at ack): next address is 0 and wrapped is set.
- imem_ack is ignored while imem_we=0.

Restart:
- Honoured only when busy=0: address ← BASE_ADDR, word_count ← 0, trunc_err and wrapped cleared.
- Ignored when busy=1.
- restart together with an accepting in_valid: restart is applied first, and the word loads at BASE_ADDR.

Occupancy:
- in_ready = occupancy < FIFO_DEPTH. A push is refused at full even if a pop occurs in the same cycle.
- Push and pop in the same cycle when not full: occupancy unchanged.
- Words are written to memory in acceptance order; none are dropped or duplicated.

## Timing

- Reset values:
  - in_ready=0 while rst=1, then 1 on the first cycle after reset is released
  - imem_we=0, imem_addr=BASE_ADDR, imem_wdata=0
  - busy=0, word_count=0, trunc_err=0, wrapped=0
  - FIFO empty, FSM in IDLE
- Latency: a word accepted at edge k is presented with imem_we=1 from the cycle after edge k.
- Throughput: with imem_ack held high, one word per cycle back-to-back, with no idle cycle between words.
- busy rises in the cycle after the first accept and falls in the cycle after the last ack.
- rst asserted mid-write: at the next edge imem_we=0 and the FIFO is emptied. Buffered words are discarded and all outputs return to reset values.

## Test plan

- ADD rd=1 rs=2 rt=3, imem_ack=1 -> one cycle later imem_we=1, imem_addr=0, imem_wdata=16'h0123. Next cycle imem_we=0, word_count=1, busy=0.
- IMMEDIATE rd=4 imm=12'h1A5 -> imem_wdata=16'hB4A5, trunc_err=1. Then JUMP imm=12'hABC -> 16'hCABC, trunc_err stays 1.
- imem_ack=0, offer 5 words (NOP, NOT rd=2 rs=7, STORE rt=5 rs=6 imm=3, BEQ rs=1 rt=2 imm=9, ADD) -> first 4 accepted, then in_ready=0, imem_wdata held at 16'hF000. Pulse ack 4 times -> 16'hF000, 16'h7270, 16'h9563, 16'hD129 at addresses 0–3.
- ADDR_W=2, stream 5 words with ack=1 -> addresses 0,1,2,3,0; wrapped=1 after the 4th ack; word_count=5.
- restart while busy=1 -> ignored, and the address sequence continues. restart with busy=0 -> next word at BASE_ADDR, word_count=0, flags cleared.
- rst for one cycle during WRITE with 3 words buffered -> imem_we=0 next cycle, busy=0. A following word loads at BASE_ADDR.

Source files
------------

// File: rtl/instr_encoder.sv
// instr_encoder: packs decoded instruction fields into 16-bit words and
// streams them through a small FIFO into instruction memory.
module instr_encoder #(
   parameter int ADDR_W     = 8,
   parameter int FIFO_DEPTH = 4,
   parameter int BASE_ADDR  = 0
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [3:0]        in_op,
   input  logic [3:0]        in_rd,
   input  logic [3:0]        in_rs,
   input  logic [3:0]        in_rt,
   input  logic [11:0]       in_imm,
   input  logic              restart,
   output logic              imem_we,
   output logic [ADDR_W-1:0] imem_addr,
   output logic [15:0]       imem_wdata,
   input  logic              imem_ack,
   output logic              busy,
   output logic [ADDR_W:0]   word_count,
   output logic              trunc_err,
   output logic              wrapped
);

   localparam int PW = $clog2(FIFO_DEPTH);
   localparam logic [ADDR_W-1:0] LP_BASE = ADDR_W'(BASE_ADDR);
   localparam logic [PW:0] LP_DEPTH = (PW+1)'(FIFO_DEPTH);

   typedef enum logic {
      S_IDLE,
      S_WRITE
   } state_t;

   state_t            r_state;
   state_t            w_next;
   logic [15:0]       r_mem [FIFO_DEPTH];
   logic [PW-1:0]     r_wptr;
   logic [PW-1:0]     r_rptr;
   logic [PW:0]       r_count;
   logic [PW:0]       w_count_nxt;
   logic [ADDR_W-1:0] r_addr;
   logic [ADDR_W:0]   r_wcnt;
   logic              r_trunc;
   logic              r_wrap;
   logic [15:0]       w_word;
   logic              w_trunc;
   logic              w_push;
   logic              w_pop;
   logic              w_restart;

   // Pack fields; w_trunc flags immediate bits that do not fit the field.
   always_comb begin
      w_word  = 16'h0000;
      w_trunc = 1'b0;
      unique case (in_op)
         4'h0, 4'h1, 4'h2, 4'h3, 4'h4, 4'h5, 4'h6:
            w_word = {in_op, in_rd, in_rs, in_rt};
         4'h7, 4'hA:
            w_word = {in_op, in_rd, in_rs, 4'h0};
         4'h8: begin
            w_word  = {in_op, in_rd, in_rs, in_imm[3:0]};
            w_trunc = |in_imm[11:4];
         end
         4'h9: begin
            w_word  = {in_op, in_rt, in_rs, in_imm[3:0]};
            w_trunc = |in_imm[11:4];
         end
         4'hB: begin
            w_word  = {in_op, in_rd, in_imm[7:0]};
            w_trunc = |in_imm[11:8];
         end
         4'hC:
            w_word = {in_op, in_imm};
         4'hD, 4'hE: begin
            w_word  = {in_op, in_rs, in_rt, in_imm[3:0]};
            w_trunc = |in_imm[11:4];
         end
         default:
            w_word = 16'hF000;
      endcase
   end

   assign in_ready    = !rst && (r_count < LP_DEPTH);
   assign w_push      = in_valid && in_ready;
   assign imem_we     = (r_state == S_WRITE);
   assign w_pop       = imem_we && imem_ack;
   assign busy        = (r_count != '0);
   assign w_restart   = restart && !busy;
   assign w_count_nxt = r_count + {{PW{1'b0}}, w_push}
                                - {{PW{1'b0}}, w_pop};

   assign imem_addr  = r_addr;
   assign imem_wdata = imem_we ? r_mem[r_rptr] : 16'h0000;
   assign word_count = r_wcnt;
   assign trunc_err  = r_trunc;
   assign wrapped    = r_wrap;

   always_comb begin
      w_next = r_state;
      unique case (r_state)
         S_IDLE:
            if (r_count != '0 || w_push) w_next = S_WRITE;
         S_WRITE:
            if (w_count_nxt == '0) w_next = S_IDLE;
         default:
            w_next = S_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (w_push) r_mem[r_wptr] <= w_word;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state <= S_IDLE;
         r_wptr  <= '0;
         r_rptr  <= '0;
         r_count <= '0;
         r_addr  <= LP_BASE;
         r_wcnt  <= '0;
         r_trunc <= 1'b0;
         r_wrap  <= 1'b0;
      end else begin
         r_state <= w_next;
         r_count <= w_count_nxt;
         if (w_push) r_wptr <= r_wptr + 1'b1;
         if (w_pop) r_rptr <= r_rptr + 1'b1;
         // Restart only happens when idle, so it never races an ack.
         if (w_restart) begin
            r_addr  <= LP_BASE;
            r_wcnt  <= '0;
            r_wrap  <= 1'b0;
            r_trunc <= w_push && w_trunc;
         end else begin
            if (w_pop) begin
               r_addr <= r_addr + 1'b1;
               r_wcnt <= r_wcnt + 1'b1;
               if (&r_addr) r_wrap <= 1'b1;
            end
            if (w_push && w_trunc) r_trunc <= 1'b1;
         end
      end
   end

endmodule

// File: tb/tb_instr_encoder.sv
// tb_instr_encoder: directed vectors for field packing plus hand-written
// sequences for back-pressure, wrap, restart and mid-write reset.
module tb_instr_encoder;

   typedef struct {
      logic [3:0]  op;
      logic [3:0]  rd;
      logic [3:0]  rs;
      logic [3:0]  rt;
      logic [11:0] imm;
      logic [15:0] word;
      logic        trunc;
   } vec_t;

   logic        clk;
   logic        rst;
   logic        in_valid;
   logic [3:0]  in_op;
   logic [3:0]  in_rd;
   logic [3:0]  in_rs;
   logic [3:0]  in_rt;
   logic [11:0] in_imm;
   logic        restart;
   logic        imem_ack;

   logic        in_ready;
   logic        imem_we;
   logic [7:0]  imem_addr;
   logic [15:0] imem_wdata;
   logic        busy;
   logic [8:0]  word_count;
   logic        trunc_err;
   logic        wrapped;

   logic        in_ready2;
   logic        we2;
   logic [1:0]  addr2;
   logic [15:0] wdata2;
   logic        busy2;
   logic [2:0]  wc2;
   logic        trunc2;
   logic        wrap2;

   int n_tests = 0;
   int n_fail  = 0;

   vec_t vecs [15];
   vec_t seqb [5];

   instr_encoder u_dut (
      .clk(clk), .rst(rst),
      .in_valid(in_valid), .in_ready(in_ready),
      .in_op(in_op), .in_rd(in_rd), .in_rs(in_rs),
      .in_rt(in_rt), .in_imm(in_imm),
      .restart(restart),
      .imem_we(imem_we), .imem_addr(imem_addr),
      .imem_wdata(imem_wdata), .imem_ack(imem_ack),
      .busy(busy), .word_count(word_count),
      .trunc_err(trunc_err), .wrapped(wrapped)
   );

   instr_encoder #(.ADDR_W(2)) u_dut2 (
      .clk(clk), .rst(rst),
      .in_valid(in_valid), .in_ready(in_ready2),
      .in_op(in_op), .in_rd(in_rd), .in_rs(in_rs),
      .in_rt(in_rt), .in_imm(in_imm),
      .restart(restart),
      .imem_we(we2), .imem_addr(addr2),
      .imem_wdata(wdata2), .imem_ack(imem_ack),
      .busy(busy2), .word_count(wc2),
      .trunc_err(trunc2), .wrapped(wrap2)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string nm, input logic [31:0] act,
                      input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", nm, act, exp);
      end
   endtask

   task automatic apply(input vec_t v);
      in_op  = v.op;
      in_rd  = v.rd;
      in_rs  = v.rs;
      in_rt  = v.rt;
      in_imm = v.imm;
   endtask

   initial begin
      vecs[0]  = '{4'h0, 4'h1, 4'h2, 4'h3, 12'h000, 16'h0123, 1'b0};
      vecs[1]  = '{4'h1, 4'hF, 4'hE, 4'hD, 12'hFFF, 16'h1FED, 1'b0};
      vecs[2]  = '{4'h6, 4'h9, 4'h8, 4'h7, 12'h000, 16'h6987, 1'b0};
      vecs[3]  = '{4'h7, 4'h2, 4'h7, 4'h5, 12'h000, 16'h7270, 1'b0};
      vecs[4]  = '{4'hA, 4'h3, 4'h4, 4'hF, 12'h000, 16'hA340, 1'b0};
      vecs[5]  = '{4'h8, 4'h1, 4'h2, 4'h0, 12'h00C, 16'h812C, 1'b0};
      vecs[6]  = '{4'h8, 4'h1, 4'h2, 4'h0, 12'h01C, 16'h812C, 1'b1};
      vecs[7]  = '{4'h9, 4'hF, 4'h6, 4'h5, 12'h003, 16'h9563, 1'b0};
      vecs[8]  = '{4'hB, 4'h4, 4'h0, 4'h0, 12'h1A5, 16'hB4A5, 1'b1};
      vecs[9]  = '{4'hB, 4'h4, 4'h3, 4'h0, 12'h0FF, 16'hB4FF, 1'b0};
      vecs[10] = '{4'hC, 4'h0, 4'h0, 4'h0, 12'hABC, 16'hCABC, 1'b0};
      vecs[11] = '{4'hD, 4'h0, 4'h1, 4'h2, 12'h009, 16'hD129, 1'b0};
      vecs[12] = '{4'hE, 4'h0, 4'h3, 4'h4, 12'hF10, 16'hE340, 1'b1};
      vecs[13] = '{4'hF, 4'h5, 4'h5, 4'h5, 12'hFFF, 16'hF000, 1'b0};
      vecs[14] = '{4'hC, 4'h7, 4'h7, 4'h7, 12'hFFF, 16'hCFFF, 1'b0};

      seqb[0] = '{4'hF, 4'h1, 4'h2, 4'h3, 12'hFFF, 16'hF000, 1'b0};
      seqb[1] = '{4'h7, 4'h2, 4'h7, 4'h0, 12'h000, 16'h7270, 1'b0};
      seqb[2] = '{4'h9, 4'h0, 4'h6, 4'h5, 12'h003, 16'h9563, 1'b0};
      seqb[3] = '{4'hD, 4'h0, 4'h1, 4'h2, 12'h009, 16'hD129, 1'b0};
      seqb[4] = '{4'h0, 4'h1, 4'h2, 4'h3, 12'h000, 16'h0123, 1'b0};

      rst = 1'b1; in_valid = 1'b0; restart = 1'b0; imem_ack = 1'b0;
      in_op = '0; in_rd = '0; in_rs = '0; in_rt = '0; in_imm = '0;

      // reset state
      repeat (2) @(negedge clk);
      chk("rst_ready", 32'(in_ready), 0);
      rst = 1'b0;
      @(negedge clk);
      chk("rel_ready", 32'(in_ready), 1);
      chk("rel_we", 32'(imem_we), 0);
      chk("rel_addr", 32'(imem_addr), 0);
      chk("rel_wdata", 32'(imem_wdata), 0);
      chk("rel_busy", 32'(busy), 0);
      chk("rel_wc", 32'(word_count), 0);
      chk("rel_trunc", 32'(trunc_err), 0);
      chk("rel_wrap", 32'(wrapped), 0);

      // encoding table: each word loaded after a restart
      imem_ack = 1'b1;
      for (int i = 0; i < 15; i++) begin
         apply(vecs[i]);
         in_valid = 1'b1;
         restart  = 1'b1;
         @(negedge clk);
         in_valid = 1'b0;
         restart  = 1'b0;
         chk($sformatf("v%0d_we", i), 32'(imem_we), 1);
         chk($sformatf("v%0d_word", i), 32'(imem_wdata),
             32'(vecs[i].word));
         chk($sformatf("v%0d_addr", i), 32'(imem_addr), 0);
         chk($sformatf("v%0d_trunc", i), 32'(trunc_err),
             32'(vecs[i].trunc));
         @(negedge clk);
         chk($sformatf("v%0d_we_off", i), 32'(imem_we), 0);
         chk($sformatf("v%0d_wc", i), 32'(word_count), 1);
         chk($sformatf("v%0d_busy", i), 32'(busy), 0);
      end

      // sticky trunc_err
      apply(vecs[8]);
      in_valid = 1'b1;
      @(negedge clk);
      chk("sa_word0", 32'(imem_wdata), 32'h0000B4A5);
      chk("sa_addr0", 32'(imem_addr), 1);
      chk("sa_trunc0", 32'(trunc_err), 1);
      apply(vecs[10]);
      @(negedge clk);
      in_valid = 1'b0;
      chk("sa_word1", 32'(imem_wdata), 32'h0000CABC);
      chk("sa_trunc1", 32'(trunc_err), 1);
      @(negedge clk);
      chk("sa_wc", 32'(word_count), 3);
      chk("sa_trunc2", 32'(trunc_err), 1);
      restart = 1'b1;
      @(negedge clk);
      restart = 1'b0;
      chk("sa_rs_trunc", 32'(trunc_err), 0);
      chk("sa_rs_wc", 32'(word_count), 0);
      chk("sa_rs_addr", 32'(imem_addr), 0);

      // back-pressure: fill the FIFO with ack low
      imem_ack = 1'b0;
      for (int i = 0; i < 4; i++) begin
         apply(seqb[i]);
         in_valid = 1'b1;
         @(negedge clk);
      end
      apply(seqb[4]);
      chk("sb_ready_full", 32'(in_ready), 0);
      chk("sb_we", 32'(imem_we), 1);
      chk("sb_hold0", 32'(imem_wdata), 32'h0000F000);
      chk("sb_busy", 32'(busy), 1);
      chk("sb_trunc", 32'(trunc_err), 0);
      @(negedge clk);
      chk("sb_ready_full2", 32'(in_ready), 0);
      chk("sb_hold1", 32'(imem_wdata), 32'h0000F000);
      chk("sb_hold_addr", 32'(imem_addr), 0);
      // first pulse happens with a 5th word still offered at full
      for (int i = 0; i < 4; i++) begin
         chk($sformatf("sb_w%0d_we", i), 32'(imem_we), 1);
         chk($sformatf("sb_w%0d_addr", i), 32'(imem_addr), i);
         chk($sformatf("sb_w%0d_word", i), 32'(imem_wdata),
             32'(seqb[i].word));
         imem_ack = 1'b1;
         @(negedge clk);
         imem_ack = 1'b0;
         in_valid = 1'b0;
         chk($sformatf("sb_w%0d_ready", i), 32'(in_ready), 1);
         @(negedge clk);
      end
      chk("sb_end_we", 32'(imem_we), 0);
      chk("sb_end_busy", 32'(busy), 0);
      chk("sb_end_wc", 32'(word_count), 4);
      chk("sb_end_addr", 32'(imem_addr), 4);

      // address wrap on the 2-bit instance, ack held high
      restart = 1'b1;
      @(negedge clk);
      restart  = 1'b0;
      imem_ack = 1'b1;
      for (int j = 0; j < 5; j++) begin
         in_op = 4'h0;
         in_rd = 4'(j);
         in_rs = 4'(j + 1);
         in_rt = 4'(j + 2);
         in_imm = '0;
         in_valid = 1'b1;
         @(negedge clk);
         chk($sformatf("sc_w%0d_we", j), 32'(we2), 1);
         chk($sformatf("sc_w%0d_addr", j), 32'(addr2), j % 4);
         chk($sformatf("sc_w%0d_word", j), 32'(wdata2),
             32'({4'h0, 4'(j), 4'(j + 1), 4'(j + 2)}));
         chk($sformatf("sc_w%0d_wrap", j), 32'(wrap2), 32'(j == 4));
      end
      in_valid = 1'b0;
      @(negedge clk);
      chk("sc_we", 32'(we2), 0);
      chk("sc_wc2", 32'(wc2), 5);
      chk("sc_wrap2", 32'(wrap2), 1);
      chk("sc_busy2", 32'(busy2), 0);
      chk("sc_ready2", 32'(in_ready2), 1);
      chk("sc_trunc2", 32'(trunc2), 0);
      chk("sc_addr1", 32'(imem_addr), 5);
      chk("sc_wc1", 32'(word_count), 5);
      chk("sc_wrap1", 32'(wrapped), 0);

      // restart ignored while busy, honoured when idle
      imem_ack = 1'b0;
      apply(vecs[0]);
      in_valid = 1'b1;
      @(negedge clk);
      in_valid = 1'b0;
      restart  = 1'b1;
      @(negedge clk);
      restart = 1'b0;
      chk("sd_addr_hold", 32'(imem_addr), 5);
      chk("sd_wc_hold", 32'(word_count), 5);
      chk("sd_busy", 32'(busy), 1);
      chk("sd_wrap2_hold", 32'(wrap2), 1);
      imem_ack = 1'b1;
      @(negedge clk);
      imem_ack = 1'b0;
      chk("sd_we_off", 32'(imem_we), 0);
      chk("sd_wc6", 32'(word_count), 6);
      chk("sd_addr6", 32'(imem_addr), 6);
      restart = 1'b1;
      @(negedge clk);
      restart = 1'b0;
      chk("sd_rs_addr", 32'(imem_addr), 0);
      chk("sd_rs_wc", 32'(word_count), 0);
      chk("sd_rs_wrap2", 32'(wrap2), 0);
      chk("sd_rs_addr2", 32'(addr2), 0);

      // reset during WRITE with three words buffered
      imem_ack = 1'b1;
      apply(vecs[2]);
      in_valid = 1'b1;
      @(negedge clk);
      in_valid = 1'b0;
      @(negedge clk);
      chk("se_addr1", 32'(imem_addr), 1);
      imem_ack = 1'b0;
      for (int i = 0; i < 3; i++) begin
         apply(vecs[i]);
         in_valid = 1'b1;
         @(negedge clk);
      end
      in_valid = 1'b0;
      chk("se_busy", 32'(busy), 1);
      rst = 1'b1;
      @(negedge clk);
      chk("se_rst_we", 32'(imem_we), 0);
      chk("se_rst_busy", 32'(busy), 0);
      chk("se_rst_ready", 32'(in_ready), 0);
      chk("se_rst_addr", 32'(imem_addr), 0);
      chk("se_rst_wc", 32'(word_count), 0);
      chk("se_rst_wdata", 32'(imem_wdata), 0);
      rst = 1'b0;
      apply(vecs[4]);
      in_valid = 1'b1;
      imem_ack = 1'b1;
      @(negedge clk);
      in_valid = 1'b0;
      chk("se_new_we", 32'(imem_we), 1);
      chk("se_new_addr", 32'(imem_addr), 0);
      chk("se_new_word", 32'(imem_wdata), 32'h0000A340);
      @(negedge clk);
      chk("se_end_we", 32'(imem_we), 0);
      chk("se_end_busy", 32'(busy), 0);
      chk("se_end_wc", 32'(word_count), 1);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
